// File: rtl/priority_coder.sv
// priority_coder: registered highest/lowest set-bit encoder with zero flag.
// One word may be accepted per clock; results appear one cycle after sampling.
// Optional feature: define PRIORITY_CODER_ONEHOT_EN to add the registered
// msb_onehot output (one-hot form of msb_index, all zeros for a zero word).
module priority_coder #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] input_word,
  input  logic             in_valid,
  output logic [IDX_W-1:0] msb_index,
  output logic [IDX_W-1:0] lsb_index,
  output logic             zero,
`ifdef PRIORITY_CODER_ONEHOT_EN
  output logic [WIDTH-1:0] msb_onehot,
`endif
  output logic             out_valid
);

  logic [IDX_W-1:0] msb_c;
  logic [IDX_W-1:0] lsb_c;
  logic             zero_c;
  logic             lsb_found;

  // Scan upward: the last set bit seen is the MSB, the first one seen is the LSB.
  always_comb begin
    msb_c     = '0;
    lsb_c     = '0;
    lsb_found = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (input_word[i[IDX_W-1:0]]) begin
        msb_c = i[IDX_W-1:0];
        if (!lsb_found) begin
          lsb_c     = i[IDX_W-1:0];
          lsb_found = 1'b1;
        end
      end
    end
    zero_c = ~|input_word;
  end

  // Result registers load only on accepted words; out_valid tracks in_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msb_index <= '0;
      lsb_index <= '0;
      zero      <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        msb_index <= msb_c;
        lsb_index <= lsb_c;
        zero      <= zero_c;
      end
    end
  end

`ifdef PRIORITY_CODER_ONEHOT_EN
  logic [WIDTH-1:0] onehot_c;

  // One-hot of the MSB position; stays all zeros when the word is zero.
  always_comb begin
    onehot_c = '0;
    if (!zero_c) begin
      onehot_c[msb_c] = 1'b1;
    end
  end

  // Same load timing as msb_index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msb_onehot <= '0;
    end else if (in_valid) begin
      msb_onehot <= onehot_c;
    end
  end
`endif

endmodule

// File: tb/tb_priority_coder.sv
// Self-checking bench for priority_coder (WIDTH=8): exhaustive sweep, directed
// cases, hold, async reset, back-to-back and random traffic against a model.
module tb_priority_coder;

  logic       clk;
  logic       rst_n;
  logic [7:0] input_word;
  logic       in_valid;
  logic [2:0] msb_index;
  logic [2:0] lsb_index;
  logic       zero;
  logic       out_valid;
`ifdef PRIORITY_CODER_ONEHOT_EN
  logic [7:0] msb_onehot;
`endif

  int errors = 0;
  int checks = 0;

  // Reference state: what the outputs should show after the latest edge.
  int         m_msb;
  int         m_lsb;
  logic       m_zero;
  logic       m_ov;
  logic [7:0] m_onehot;

  priority_coder #(.WIDTH(8), .IDX_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .input_word (input_word),
    .in_valid   (in_valid),
    .msb_index  (msb_index),
    .lsb_index  (lsb_index),
    .zero       (zero),
`ifdef PRIORITY_CODER_ONEHOT_EN
    .msb_onehot (msb_onehot),
`endif
    .out_valid  (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // floor(log2(v)) by repeated halving; 0 for v=0.
  function automatic int ref_msb(input int v);
    int r = 0;
    while (v > 1) begin
      v = v / 2;
      r++;
    end
    return r;
  endfunction

  // Count of trailing zeros; 0 for v=0.
  function automatic int ref_lsb(input int v);
    int r = 0;
    if (v == 0) return 0;
    while (v % 2 == 0) begin
      v = v / 2;
      r++;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_msb = 0; m_lsb = 0; m_zero = 1'b1; m_ov = 1'b0; m_onehot = 8'h00;
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".msb"},  64'(msb_index), 64'(m_msb));
    chk({tag, ".lsb"},  64'(lsb_index), 64'(m_lsb));
    chk({tag, ".zero"}, 64'(zero),      64'(m_zero));
    chk({tag, ".ov"},   64'(out_valid), 64'(m_ov));
`ifdef PRIORITY_CODER_ONEHOT_EN
    chk({tag, ".onehot"}, 64'(msb_onehot), 64'(m_onehot));
`endif
  endtask

  // Drive one cycle (inputs change 1 time unit after an edge), clock it, update
  // the model and compare all outputs 1 time unit after the sampling edge.
  task automatic apply(input logic [7:0] w, input logic v, input string tag);
    input_word = w;
    in_valid   = v;
    @(posedge clk);
    #1;
    if (v) begin
      m_zero   = (w == 8'h00);
      m_msb    = ref_msb(int'(w));
      m_lsb    = ref_lsb(int'(w));
      m_onehot = (w == 8'h00) ? 8'h00 : 8'(1 << m_msb);
    end
    m_ov = v;
    chk_all(tag);
  endtask

  initial begin
    rst_n      = 1'b0;
    input_word = 8'hA5;
    in_valid   = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset");
    rst_n = 1'b1;

    // Exhaustive sweep of every 8-bit value, one per cycle.
    for (int v = 0; v < 256; v++) apply(8'(v), 1'b1, "sweep");

    // Directed values with literal expectations.
    apply(8'h80, 1'b1, "d80");
    chk("d80.msb_lit", 64'(msb_index), 64'd7); chk("d80.lsb_lit", 64'(lsb_index), 64'd7);
    apply(8'h01, 1'b1, "d01");
    chk("d01.msb_lit", 64'(msb_index), 64'd0); chk("d01.lsb_lit", 64'(lsb_index), 64'd0);
    apply(8'hFF, 1'b1, "dFF");
    chk("dFF.msb_lit", 64'(msb_index), 64'd7); chk("dFF.lsb_lit", 64'(lsb_index), 64'd0);
    apply(8'h28, 1'b1, "d28");
    chk("d28.msb_lit", 64'(msb_index), 64'd5); chk("d28.lsb_lit", 64'(lsb_index), 64'd3);

    // Hold: outputs keep the last accepted word while in_valid is low.
    apply(8'h10, 1'b1, "hold_acc");
    for (int k = 0; k < 3; k++) begin
      apply(8'h01, 1'b0, "hold");
      chk("hold.msb_lit", 64'(msb_index), 64'd4);
      chk("hold.ov_lit",  64'(out_valid), 64'd0);
    end

    // Async reset mid-cycle with a word in flight.
    apply(8'h44, 1'b1, "pre_rst");
    #3;
    input_word = 8'h55;
    in_valid   = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_all("async_rst");
    @(posedge clk);
    #1;
    chk_all("in_rst");
    rst_n = 1'b1;
    apply(8'h06, 1'b1, "first_after_rst");
    chk("first.msb_lit", 64'(msb_index), 64'd2);

    // Back-to-back words.
    apply(8'h03, 1'b1, "b2b0");
    chk("b2b0.lit", 64'({msb_index, zero, out_valid}), 64'({3'd1, 1'b0, 1'b1}));
    apply(8'h40, 1'b1, "b2b1");
    chk("b2b1.lit", 64'({msb_index, zero, out_valid}), 64'({3'd6, 1'b0, 1'b1}));
    apply(8'h00, 1'b1, "b2b2");
    chk("b2b2.lit", 64'({msb_index, zero, out_valid}), 64'({3'd0, 1'b1, 1'b1}));

`ifdef PRIORITY_CODER_ONEHOT_EN
    apply(8'h2C, 1'b1, "oh2C");
    chk("oh2C.lit", 64'(msb_onehot), 64'h20);
    apply(8'h00, 1'b1, "oh00");
    chk("oh00.lit", 64'(msb_onehot), 64'h00);
`endif

    // Random traffic with random gaps.
    for (int k = 0; k < 300; k++) begin
      apply(8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/priority_coder.md
PRIORITY_CODER -- requirements
Module: priority_coder

Interface
REQ-001 Parameter WIDTH, default 8, meaning input word width in bits; legal values are powers of two from 2 to 64.
REQ-002 Parameter IDX_W, default 3, meaning index width; it SHALL equal log2(WIDTH).
REQ-003 Port clk  input  1  meaning the single clock; all state is updated on its rising edge.
REQ-004 Port rst_n  input  1  meaning reset, asynchronous and active-low.
REQ-005 Port input_word  input  WIDTH  meaning the word to be encoded.
REQ-006 Port in_valid  input  1  meaning input_word is sampled on this clock edge.
REQ-007 Port msb_index  output  IDX_W  meaning the bit position of the highest set bit of the sampled word (registered).
REQ-008 Port lsb_index  output  IDX_W  meaning the bit position of the lowest set bit of the sampled word (registered).
REQ-009 Port zero  output  1  meaning the sampled word was all zeros (registered).
REQ-010 Port out_valid  output  1  meaning the outputs hold the result of a word sampled on the previous edge.

Function
REQ-011 On a rising clk edge with in_valid=1, the block SHALL register msb_index = the largest i with input_word[i]=1.
REQ-012 On the same edge, the block SHALL register lsb_index = the smallest i with input_word[i]=1.
REQ-013 Latency SHALL be exactly 1 cycle from the sampling edge to the result outputs; there is no backpressure, and a new word can be accepted every cycle.
REQ-014 If the sampled word is 0, the block SHALL register msb_index=0, lsb_index=0 and zero=1; otherwise it SHALL register zero=0.
REQ-015 If exactly one bit is set, msb_index and lsb_index SHALL be equal.
REQ-016 out_valid SHALL be registered from in_valid, so it is high in the cycle after each accepted word.
REQ-017 When in_valid=0, msb_index, lsb_index and zero SHALL hold their previous values, and out_valid SHALL be 0.
REQ-018 Index computation SHALL be purely combinational from input_word into the output registers; the design SHALL have no multi-cycle paths and no state machine.

Reset
REQ-019 While rst_n=0, the block SHALL immediately clear msb_index, lsb_index and out_valid to 0 and set zero to 1, independent of clk.
REQ-020 Reset deassertion SHALL be used synchronously to clk; the first word accepted is the one sampled on the first rising edge with rst_n=1 and in_valid=1.
REQ-021 If reset is asserted while a word is in flight, that result SHALL be discarded and out_valid SHALL be 0.

Configuration
REQ-022 With macro PRIORITY_CODER_ONEHOT_EN defined, the block SHALL add output msb_onehot (WIDTH bits, registered with the same timing as msb_index) with only bit msb_index set, or all zeros when zero=1, and reset value 0.
REQ-023 Without PRIORITY_CODER_ONEHOT_EN, the msb_onehot port and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-024 Exhaustive sweep: input_word = 0..255 with in_valid=1, one value per cycle -> each following cycle msb_index = floor(log2(v)) and lsb_index = index of the lowest set bit; for v=0, zero=1 with both indices 0.
REQ-025 Directed: 8'h80 -> msb_index=7, lsb_index=7; 8'h01 -> 0/0; 8'hFF -> msb_index=7, lsb_index=0; 8'h28 -> msb_index=5, lsb_index=3.
REQ-026 Hold: accept 8'h10, then drive in_valid=0 with input_word=8'h01 for 3 cycles -> msb_index stays 4 and out_valid=0.
REQ-027 Async reset: drop rst_n mid-cycle while out_valid=1 -> outputs become 0 with zero=1 before the next clk edge; the first valid result after release is the first sampled word.
REQ-028 Back-to-back: 8'h03, 8'h40, 8'h00 on consecutive cycles -> msb_index 1, 6, 0 and zero 0, 0, 1 on consecutive cycles with out_valid held at 1.
REQ-029 With PRIORITY_CODER_ONEHOT_EN defined: 8'h2C -> msb_onehot=8'h20; 8'h00 -> msb_onehot=8'h00.
